matrix_result_checker: RTL and testbench

MATRIX_RESULT_CHECKER -- requirements
Module: matrix_result_checker

---
 rtl/matrix_result_checker_pkg.sv | 27 ++
 rtl/matrix_result_checker_stall_gen.sv | 29 ++
 rtl/matrix_result_checker.sv | 125 ++++++++++++
 tb/tb_matrix_result_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_result_checker_pkg.sv
// Shared types and constants for the matrix multiplier result checker.
// Holds the FSM state encoding, err_flags bit positions and counter width.
package matrix_result_checker_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int ERR_BAD_HDR      = 0;
   localparam int ERR_DATA         = 1;
   localparam int ERR_EARLY_LAST   = 2;
   localparam int ERR_MISSING_LAST = 3;

   // Saturating add used by both status counters.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [2:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-2){1'b0}}, inc};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/matrix_result_checker_stall_gen.sv
// Free-running backpressure pulse generator: stall is high one cycle in
// every STALL_PERIOD cycles; STALL_PERIOD = 0 never stalls.
module stall_gen
   import matrix_result_checker_pkg::*;
#(
   parameter int STALL_PERIOD = 0
) (
   input  logic clk,
   input  logic reset,
   output logic stall
);

   localparam logic [CNT_W-1:0] WRAP = CNT_W'(STALL_PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   // With STALL_PERIOD = 0 the counter simply wraps at 16'hFFFF and is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (cnt == WRAP)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign stall = (STALL_PERIOD != 0) && (cnt == WRAP);

endmodule

// File: rtl/matrix_result_checker.sv
// Checks framed result streams (header + FRAME_LEN payload beats) from the
// matrix multiplier and reports frame/error status. A beat moves when TVALID and TREADY are both high at posedge.
module matrix_result_checker
   import matrix_result_checker_pkg::*;
#(
   parameter int          FRAME_LEN    = 144,
   parameter logic [31:0] EXPECT_DATA  = 32'd12,
   parameter logic [7:0]  HEADER_TAG   = 8'hFF,
   parameter int          NUM_FRAMES   = 2,
   parameter int          STALL_PERIOD = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] output_r_TDATA_0,
   input  logic        output_r_TVALID_0,
   input  logic        output_r_TLAST_0,
   output logic        output_r_TREADY_0,
   output logic [15:0] frame_count,
   output logic [15:0] error_count,
   output logic [3:0]  err_flags,
   output logic [15:0] last_header,
   output logic        done,
   output logic        pass,
   output logic [1:0]  state_dbg
);

   localparam logic [CNT_W-1:0] FRAME_LEN_C  = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] NUM_FRAMES_C = CNT_W'(NUM_FRAMES);

   state_t           state;
   logic [CNT_W-1:0] beat_idx;
   logic [CNT_W-1:0] idx_inc;
   logic [CNT_W-1:0] frame_next;
   logic [CNT_W-1:0] err_next;
   logic [3:0]       flag_set;
   logic [2:0]       err_inc;
   logic             stall;
   logic             accept;
   logic             frame_end;
   logic             go_done;

   stall_gen #(.STALL_PERIOD(STALL_PERIOD)) u_stall_gen (
      .clk   (clk),
      .reset (reset),
      .stall (stall)
   );

   assign accept  = output_r_TVALID_0 & output_r_TREADY_0;
   assign idx_inc = beat_idx + CNT_W'(1);

   // Per-beat error decode; only takes effect on an accepted beat.
   always_comb begin
      flag_set  = '0;
      frame_end = 1'b0;
      case (state)
         ST_HDR: begin
            flag_set[ERR_BAD_HDR]    = output_r_TDATA_0[31:24] != HEADER_TAG;
            flag_set[ERR_EARLY_LAST] = output_r_TLAST_0;
            frame_end                = output_r_TLAST_0;
         end
         ST_PAYLOAD: begin
            flag_set[ERR_DATA] = output_r_TDATA_0 != EXPECT_DATA;
            if (output_r_TLAST_0) begin
               frame_end                = 1'b1;
               flag_set[ERR_EARLY_LAST] = idx_inc < FRAME_LEN_C;
            end else begin
               flag_set[ERR_MISSING_LAST] = idx_inc == FRAME_LEN_C;
            end
         end
         ST_DRAIN: frame_end = output_r_TLAST_0;
         default: ;
      endcase
   end

   assign err_inc    = 3'(flag_set[0]) + 3'(flag_set[1]) + 3'(flag_set[2]) + 3'(flag_set[3]);
   assign err_next   = sat_add(error_count, err_inc);
   assign frame_next = sat_add(frame_count, 3'd1);
   assign go_done    = accept && frame_end && (frame_next >= NUM_FRAMES_C);
   assign state_dbg  = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= ST_HDR;
         output_r_TREADY_0 <= 1'b0;
         beat_idx          <= '0;
         frame_count       <= '0;
         error_count       <= '0;
         err_flags         <= '0;
         last_header       <= '0;
         done              <= 1'b0;
         pass              <= 1'b0;
      end else begin
         output_r_TREADY_0 <= (state != ST_DONE) && !go_done && !stall;
         if (accept) begin
            err_flags   <= err_flags | flag_set;
            error_count <= err_next;
            case (state)
               ST_HDR: begin
                  last_header <= output_r_TDATA_0[15:0];
                  state       <= ST_PAYLOAD;
               end
               ST_PAYLOAD: begin
                  beat_idx <= idx_inc;
                  if (idx_inc == FRAME_LEN_C)
                     state <= ST_DRAIN;
               end
               default: ;
            endcase
            // Frame completion overrides the per-state transition above.
            if (frame_end) begin
               frame_count <= frame_next;
               beat_idx    <= '0;
               if (go_done) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  state <= ST_HDR;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_matrix_result_checker.sv
// Bench for matrix_result_checker: one instance without and one with stalling.
// Per-frame status snapshots are queued at send time and compared at completion.
module tb_matrix_result_checker;
   import matrix_result_checker_pkg::*;

   typedef struct {
      logic [31:0] hdr;
      int          bad_idx;
      int          last_at;
      logic [3:0]  exp_flags;
      logic [15:0] exp_errs;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [31:0] tdata;
   logic        tlast;
   logic        tvalid0, tvalid3;
   logic        ready0, ready3;
   logic [15:0] fc0, ec0, lh0, fc3, ec3, lh3;
   logic [3:0]  flags0, flags3;
   logic        done0, pass0, done3, pass3;
   logic [1:0]  st0, st3;

   logic [51:0] exp_q[$];
   vec_t        vec[10];
   int          tests, fails;
   bit          use3, gaps, aborted;
   logic [15:0] acc_fc, acc_ec, prev0, prev3;
   logic [3:0]  acc_flags;

   matrix_result_checker dut0 (
      .clk(clk), .reset(rst),
      .output_r_TDATA_0(tdata), .output_r_TVALID_0(tvalid0), .output_r_TLAST_0(tlast),
      .output_r_TREADY_0(ready0), .frame_count(fc0), .error_count(ec0), .err_flags(flags0),
      .last_header(lh0), .done(done0), .pass(pass0), .state_dbg(st0)
   );

   matrix_result_checker #(.STALL_PERIOD(3)) dut3 (
      .clk(clk), .reset(rst),
      .output_r_TDATA_0(tdata), .output_r_TVALID_0(tvalid3), .output_r_TLAST_0(tlast),
      .output_r_TREADY_0(ready3), .frame_count(fc3), .error_count(ec3), .err_flags(flags3),
      .last_header(lh3), .done(done3), .pass(pass3), .state_dbg(st3)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: pop one expected snapshot every time a frame completes
   task automatic compare_frame(input logic [15:0] fc, input logic [15:0] ec,
                                input logic [3:0] fl, input logic [15:0] lh);
      logic [51:0] e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_frame: got frame_count %0d, expected no completion", fc);
      end else begin
         e = exp_q.pop_front();
         check("frame_count", 32'(fc), 32'(e[51:36]));
         check("error_count", 32'(ec), 32'(e[35:20]));
         check("err_flags",   32'(fl), 32'(e[19:16]));
         check("last_header", 32'(lh), 32'(e[15:0]));
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev0 <= 16'd0;
         prev3 <= 16'd0;
      end else begin
         if (fc0 !== prev0) begin
            compare_frame(fc0, ec0, flags0, lh0);
            prev0 <= fc0;
         end
         if (fc3 !== prev3) begin
            compare_frame(fc3, ec3, flags3, lh3);
            prev3 <= fc3;
         end
      end
   end

   // Driver tasks (inputs change on negedge; ready sampled mid-cycle)
   task automatic send_beat(input logic [31:0] d, input logic l);
      bit ok;
      if (aborted) return;
      ok    = 1'b0;
      tdata = d;
      tlast = l;
      if (use3) tvalid3 = 1'b1;
      else      tvalid0 = 1'b1;
      for (int t = 0; t < 40 && !ok; t++) begin
         ok = use3 ? ready3 : ready0;
         @(negedge clk);
      end
      tvalid0 = 1'b0;
      tvalid3 = 1'b0;
      tlast   = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         aborted = 1'b1;
         $display("FAIL beat_timeout: got tready low for 40 cycles, expected acceptance");
      end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic send_frame(input vec_t v);
      acc_fc    = acc_fc + 16'd1;
      acc_ec    = acc_ec + v.exp_errs;
      acc_flags = acc_flags | v.exp_flags;
      exp_q.push_back({acc_fc, acc_ec, acc_flags, v.hdr[15:0]});
      send_beat(v.hdr, v.last_at == 0);
      for (int i = 1; i <= v.last_at; i++)
         send_beat((i == v.bad_idx) ? 32'd13 : 32'd12, i == v.last_at);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      tvalid0 = 1'b0;
      tvalid3 = 1'b0;
      tlast   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_frame_count", 32'(fc0), 32'd0);
      check("rst_error_count", 32'(ec0), 32'd0);
      check("rst_err_flags",   32'(flags0), 32'd0);
      check("rst_last_header", 32'(lh0), 32'd0);
      check("rst_done_pass",   32'({done0, pass0}), 32'd0);
      check("rst_state",       32'(st0), 32'(ST_HDR));
      check("rst_tready",      32'({ready0, ready3}), 32'd0);
      rst = 1'b0;
      check("tready_before_first_edge", 32'({ready0, ready3}), 32'd0);
      @(negedge clk);
      check("tready_after_first_edge", 32'({ready0, ready3}), 32'b11);
      exp_q.delete();
      acc_fc    = 16'd0;
      acc_ec    = 16'd0;
      acc_flags = 4'd0;
   endtask

   task automatic finish_run(input bit exp_pass);
      repeat (3) @(negedge clk);
      check("done",           32'(use3 ? done3 : done0), 32'd1);
      check("pass",           32'(use3 ? pass3 : pass0), 32'(exp_pass));
      check("tready_in_done", 32'(use3 ? ready3 : ready0), 32'd0);
      check("state_done",     32'(use3 ? st3 : st0), 32'(ST_DONE));
      check("frames_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int lows;
      rst = 1'b1; tdata = '0; tlast = 1'b0; tvalid0 = 1'b0; tvalid3 = 1'b0;
      tests = 0; fails = 0; use3 = 1'b0; gaps = 1'b0; aborted = 1'b0;
      acc_fc = '0; acc_ec = '0; acc_flags = '0;

      //        header          bad  last  flags    errors
      vec[0] = '{32'hFF000120,   0, 144, 4'b0000, 16'd0};  // clean
      vec[1] = '{32'hFF000120,   0, 144, 4'b0000, 16'd0};  // clean
      vec[2] = '{32'hFF000120,  10, 144, 4'b0010, 16'd1};  // beat 10 = 13
      vec[3] = '{32'hFF000121,   0, 144, 4'b0000, 16'd0};
      vec[4] = '{32'hFF000120,   0, 100, 4'b0100, 16'd1};  // early TLAST
      vec[5] = '{32'hFF000122,   0, 144, 4'b0000, 16'd0};  // next beat is a header
      vec[6] = '{32'hFF000120, 147, 150, 4'b1000, 16'd1};  // missing TLAST, drained
      vec[7] = '{32'hFF000123, 144, 144, 4'b0010, 16'd1};  // bad final beat
      vec[8] = '{32'hAB000033,   0,   0, 4'b0101, 16'd2};  // bad tag + TLAST on header
      vec[9] = '{32'hFF00BEEF,  50,  50, 4'b0110, 16'd2};  // mismatch + early TLAST

      for (int r = 0; r < 5; r++) begin
         do_reset();
         send_frame(vec[2*r]);
         send_frame(vec[2*r+1]);
         finish_run(acc_ec == 16'd0);
      end

      // Reset in the middle of a frame: partial frame leaves no trace
      do_reset();
      send_beat(32'hFF000120, 1'b0);
      for (int i = 1; i < 50; i++) send_beat(32'd12, 1'b0);
      do_reset();
      send_frame(vec[0]);
      send_frame(vec[1]);
      finish_run(1'b1);

      // Stalling instance: TREADY low one cycle in three, random valid gaps
      use3 = 1'b1;
      do_reset();
      lows = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (!ready3) lows++;
      end
      check("stall_low_cycles", 32'(lows), 32'd3);
      gaps = 1'b1;
      send_frame(vec[0]);
      send_frame(vec[1]);
      finish_run(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
